// File: rtl/ysyx_23060075_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060075_pc_ctrl_pkg
// Description : Shared widths, FSM state codes and the sequential PC step
//               for the fetch/execute sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060075_pc_ctrl_pkg;

    localparam int          c_isa_width  = 32;
    localparam int          c_inst_width = 32;
    localparam logic [31:0] c_pc_step    = 32'h4;

    // Sequencer state codes
    localparam logic [1:0]  S_FETCH = 2'd0;
    localparam logic [1:0]  S_WAIT  = 2'd1;
    localparam logic [1:0]  S_EXEC  = 2'd2;
    localparam logic [1:0]  S_HALT  = 2'd3;

    // A control-transfer target must be word aligned
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060075_npc_sel.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060075_npc_sel
// Description : Next-PC priority mux (trap > mret > jump > pc+4) with
//               misalignment redirect of jump/mret targets to the trap vector.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060075_npc_sel
    import ysyx_23060075_pc_ctrl_pkg::*;
#(
    parameter int ISA_WIDTH = c_isa_width
) (
    input  logic [ISA_WIDTH-1:0] i_pc,
    input  logic                 i_jump_en,
    input  logic [ISA_WIDTH-1:0] i_jump_target,
    input  logic                 i_trap_en,
    input  logic [ISA_WIDTH-1:0] i_trap_vec,
    input  logic                 i_mret_en,
    input  logic [ISA_WIDTH-1:0] i_mepc,
    output logic [ISA_WIDTH-1:0] o_pc_next,
    output logic                 o_exc_misalign
);

    // Priority select; the trap vector itself is trusted and never checked
    always_comb begin
        o_pc_next      = i_pc + ISA_WIDTH'(c_pc_step);
        o_exc_misalign = 1'b0;
        if (i_trap_en) begin
            o_pc_next = i_trap_vec;
        end else if (i_mret_en) begin
            if (is_misaligned(i_mepc[1:0])) begin
                o_pc_next      = i_trap_vec;
                o_exc_misalign = 1'b1;
            end else begin
                o_pc_next = i_mepc;
            end
        end else if (i_jump_en) begin
            if (is_misaligned(i_jump_target[1:0])) begin
                o_pc_next      = i_trap_vec;
                o_exc_misalign = 1'b1;
            end else begin
                o_pc_next = i_jump_target;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060075_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060075_pc_ctrl
// Description : Multi-cycle fetch/execute sequencer. Owns the PC register
//               write port, issues IFU fetches, hands instructions to the EXU
//               and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060075_pc_ctrl
    import ysyx_23060075_pc_ctrl_pkg::*;
#(
    parameter int ISA_WIDTH  = c_isa_width,
    parameter int INST_WIDTH = c_inst_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ISA_WIDTH-1:0]  pc,
    output logic [ISA_WIDTH-1:0]  pc_next,
    output logic                  pc_en,
    output logic                  ifu_req_valid,
    output logic [ISA_WIDTH-1:0]  ifu_req_addr,
    input  logic                  ifu_req_ready,
    input  logic                  ifu_rsp_valid,
    input  logic [INST_WIDTH-1:0] ifu_rsp_data,
    output logic                  ifu_rsp_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  exu_start,
    input  logic                  exu_done,
    input  logic                  jump_en,
    input  logic [ISA_WIDTH-1:0]  jump_target,
    input  logic                  trap_en,
    input  logic [ISA_WIDTH-1:0]  trap_vec,
    input  logic                  mret_en,
    input  logic [ISA_WIDTH-1:0]  mepc,
    input  logic                  halt,
    output logic                  exc_misalign,
    output logic                  halted,
    output logic [63:0]           instret
);

    logic [1:0]            r_state;
    logic                  r_req_valid;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_exu_start;
    logic [63:0]           r_instret;

    logic [ISA_WIDTH-1:0]  w_pc_next;
    logic                  w_misalign;
    logic                  w_retire;

    ysyx_23060075_npc_sel #(
        .ISA_WIDTH (ISA_WIDTH)
    ) u_npc_sel (
        .i_pc           (pc),
        .i_jump_en      (jump_en),
        .i_jump_target  (jump_target),
        .i_trap_en      (trap_en),
        .i_trap_vec     (trap_vec),
        .i_mret_en      (mret_en),
        .i_mepc         (mepc),
        .o_pc_next      (w_pc_next),
        .o_exc_misalign (w_misalign)
    );

    // Retirement happens only in the EXEC cycle where the EXU reports done;
    // redirect controls are meaningful only in that cycle
    assign w_retire = (r_state == S_EXEC) && exu_done;

    // Sequencer FSM with registered request/pulse/instruction outputs.
    // The request valid is registered so it is low while reset is held; after
    // retirement it is raised together with the return to FETCH so the
    // steady-state loop stays at three cycles per instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_req_valid <= 1'b0;
            r_inst      <= '0;
            r_exu_start <= 1'b0;
            r_instret   <= '0;
        end else begin
            r_exu_start <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (!r_req_valid) begin
                        r_req_valid <= 1'b1;
                    end else if (ifu_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ifu_rsp_valid) begin
                        r_inst      <= ifu_rsp_data;
                        r_exu_start <= 1'b1;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exu_done) begin
                        r_instret <= r_instret + 64'd1;
                        if (halt) begin
                            r_state <= S_HALT;
                        end else begin
                            r_state     <= S_FETCH;
                            r_req_valid <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    r_req_valid <= 1'b0;
                end
                default: begin
                    r_state     <= S_FETCH;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Address follows the PC, which cannot change while fetching
    assign ifu_req_valid = r_req_valid;
    assign ifu_req_addr  = pc;
    assign ifu_rsp_ready = (r_state == S_WAIT);
    assign inst          = r_inst;
    assign exu_start     = r_exu_start;
    assign pc_next       = w_pc_next;
    assign pc_en         = w_retire;
    assign exc_misalign  = w_retire && w_misalign;
    assign halted        = (r_state == S_HALT);
    assign instret       = r_instret;

endmodule
`default_nettype wire
